// File: rtl/key_cond_pkg.sv
// Shared types and helpers for the key conditioner channels.
package key_cond_pkg;

   // Per-channel press tracking: not pressed, counting towards long-press, held (auto-repeat).
   typedef enum logic [1:0] {
      KC_IDLE  = 2'd0,
      KC_PRESS = 2'd1,
      KC_HELD  = 2'd2
   } kc_state_e;

   // Bits needed to hold any value 0..n.
   function automatic int cnt_w(int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/key_cond_channel.sv
// One key channel: 2-flop synchroniser, polarity normalise, debounce,
// and press/hold/repeat FSM producing registered single-cycle pulses.
module key_cond_channel
   import key_cond_pkg::*;
#(
   parameter bit          ACTIVE_LOW    = 1'b1,
   parameter int unsigned DEB_CYCLES    = 60000,
   parameter int unsigned HOLD_CYCLES   = 6000000,
   parameter int unsigned REPEAT_CYCLES = 1200000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_in,
   output logic o_pressed,
   output logic o_press,
   output logic o_release,
   output logic o_long,
   output logic o_repeat
);

   localparam int unsigned DW = cnt_w(DEB_CYCLES);
   localparam int unsigned HW = cnt_w(HOLD_CYCLES);
   // A zero repeat period still needs a 1-bit counter to keep the declarations legal.
   localparam int unsigned RW = (REPEAT_CYCLES == 0) ? 1 : cnt_w(REPEAT_CYCLES);

   localparam logic          IDLE_LVL  = ACTIVE_LOW;
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [RW-1:0] REP_LAST  = (REPEAT_CYCLES == 0) ? '0 : RW'(REPEAT_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          key_now;
   logic          toggle;
   logic          pressed_q, pressed_d;
   logic [DW-1:0] deb_cnt_q, deb_cnt_d;
   kc_state_e     state_q, state_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [RW-1:0] rep_q, rep_d;
   logic          press_q, press_d;
   logic          release_q, release_d;
   logic          long_q, long_d;
   logic          repeat_q, repeat_d;

   // Synchroniser flops reset to the idle (not pressed) pin level.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync1_q <= IDLE_LVL;
         sync2_q <= IDLE_LVL;
      end else begin
         sync1_q <= i_in;
         sync2_q <= sync1_q;
      end
   end

   assign key_now = sync2_q ^ ACTIVE_LOW;

   // Debounce: count consecutive cycles the synchronised key differs from the accepted level.
   always_comb begin
      toggle    = 1'b0;
      deb_cnt_d = '0;
      if (key_now != pressed_q) begin
         if (deb_cnt_q == DEB_LAST) begin
            toggle = 1'b1;
         end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
         end
      end
      pressed_d = pressed_q ^ toggle;
   end

   // Press FSM: edge pulses, hold timing and auto-repeat; an accepted release overrides everything.
   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      rep_d     = rep_q;
      press_d   = toggle & ~pressed_q;
      release_d = toggle & pressed_q;
      long_d    = 1'b0;
      repeat_d  = 1'b0;
      if (release_d) begin
         state_d = KC_IDLE;
         hold_d  = '0;
         rep_d   = '0;
      end else begin
         unique case (state_q)
            KC_IDLE: begin
               if (press_d) begin
                  state_d = KC_PRESS;
                  hold_d  = '0;
                  rep_d   = '0;
               end
            end
            KC_PRESS: begin
               if (hold_q == HOLD_LAST) begin
                  state_d = KC_HELD;
                  long_d  = 1'b1;
                  hold_d  = '0;
                  rep_d   = '0;
               end else begin
                  hold_d = hold_q + 1'b1;
               end
            end
            KC_HELD: begin
               if (REPEAT_CYCLES != 0) begin
                  if (rep_q == REP_LAST) begin
                     repeat_d = 1'b1;
                     rep_d    = '0;
                  end else begin
                     rep_d = rep_q + 1'b1;
                  end
               end
            end
            default: begin
               state_d = KC_IDLE;
               hold_d  = '0;
               rep_d   = '0;
            end
         endcase
      end
   end

   // Debounce, FSM and output pulse registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pressed_q <= 1'b0;
         deb_cnt_q <= '0;
         state_q   <= KC_IDLE;
         hold_q    <= '0;
         rep_q     <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;
         repeat_q  <= 1'b0;
      end else begin
         pressed_q <= pressed_d;
         deb_cnt_q <= deb_cnt_d;
         state_q   <= state_d;
         hold_q    <= hold_d;
         rep_q     <= rep_d;
         press_q   <= press_d;
         release_q <= release_d;
         long_q    <= long_d;
         repeat_q  <= repeat_d;
      end
   end

   assign o_pressed = pressed_q;
   assign o_press   = press_q;
   assign o_release = release_q;
   assign o_long    = long_q;
   assign o_repeat  = repeat_q;

endmodule

// File: rtl/key_conditioner.sv
// N_CH independent key conditioning channels between board key pins and the core.
module key_conditioner
   import key_cond_pkg::*;
#(
   parameter int unsigned N_CH          = 4,
   parameter bit          ACTIVE_LOW    = 1'b1,
   parameter int unsigned DEB_CYCLES    = 60000,
   parameter int unsigned HOLD_CYCLES   = 6000000,
   parameter int unsigned REPEAT_CYCLES = 1200000
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic [N_CH-1:0] i_in,
   output logic [N_CH-1:0] o_pressed,
   output logic [N_CH-1:0] o_press,
   output logic [N_CH-1:0] o_release,
   output logic [N_CH-1:0] o_long,
   output logic [N_CH-1:0] o_repeat
);

   for (genvar g = 0; g < int'(N_CH); g++) begin : g_ch
      key_cond_channel #(
         .ACTIVE_LOW   (ACTIVE_LOW),
         .DEB_CYCLES   (DEB_CYCLES),
         .HOLD_CYCLES  (HOLD_CYCLES),
         .REPEAT_CYCLES(REPEAT_CYCLES)
      ) u_ch (
         .i_clk    (i_clk),
         .i_rst_n  (i_rst_n),
         .i_in     (i_in[g]),
         .o_pressed(o_pressed[g]),
         .o_press  (o_press[g]),
         .o_release(o_release[g]),
         .o_long   (o_long[g]),
         .o_repeat (o_repeat[g])
      );
   end

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: stimulus queues expected pulse events,
// a monitor pops and compares whenever any pulse output is active or an event is due.
module tb_key_conditioner;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] i_in;
   logic [3:0] o_pressed, o_press, o_release, o_long, o_repeat;
   logic [3:0] i_in2;
   logic [3:0] o_pressed2, o_press2, o_release2, o_long2, o_repeat2;

   int cyc = 0;
   int checks = 0;
   int failures = 0;

   typedef struct {
      int         cyc;
      logic [3:0] pr;
      logic [3:0] rl;
      logic [3:0] lg;
      logic [3:0] rp;
   } exp_t;

   exp_t q[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   key_conditioner #(
      .N_CH(4), .ACTIVE_LOW(1'b1), .DEB_CYCLES(4), .HOLD_CYCLES(20), .REPEAT_CYCLES(5)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_in(i_in),
      .o_pressed(o_pressed), .o_press(o_press), .o_release(o_release),
      .o_long(o_long), .o_repeat(o_repeat)
   );

   key_conditioner #(
      .N_CH(4), .ACTIVE_LOW(1'b1), .DEB_CYCLES(4), .HOLD_CYCLES(20), .REPEAT_CYCLES(0)
   ) dut_norep (
      .i_clk(clk), .i_rst_n(rst_n), .i_in(i_in2),
      .o_pressed(o_pressed2), .o_press(o_press2), .o_release(o_release2),
      .o_long(o_long2), .o_repeat(o_repeat2)
   );

   task automatic push(int c, logic [3:0] pr, logic [3:0] rl, logic [3:0] lg, logic [3:0] rp);
      exp_t e;
      e.cyc = c; e.pr = pr; e.rl = rl; e.lg = lg; e.rp = rp;
      q.push_back(e);
   endtask

   task automatic chk(string name, logic [3:0] act, logic [3:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%b required=%b (cyc %0d)", name, act, req, cyc);
      end
   endtask

   task automatic chk_int(string name, int act, int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (cyc %0d)", name, act, req, cyc);
      end
   endtask

   task automatic wait_cyc(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic monitor_step();
      exp_t e;
      logic [3:0] any;
      while (q.size() > 0 && q[0].cyc < cyc) begin
         e = q.pop_front();
         checks++;
         failures++;
         $display("FAIL missed_event actual=none required=event@cyc%0d press=%b rel=%b long=%b rep=%b",
                  e.cyc, e.pr, e.rl, e.lg, e.rp);
      end
      any = o_press | o_release | o_long | o_repeat;
      if (any != 4'b0000 || (q.size() > 0 && q[0].cyc == cyc)) begin
         checks++;
         if (q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event actual=cyc%0d press=%b rel=%b long=%b rep=%b required=no event",
                     cyc, o_press, o_release, o_long, o_repeat);
         end else begin
            e = q.pop_front();
            if (e.cyc != cyc || o_press !== e.pr || o_release !== e.rl ||
                o_long !== e.lg || o_repeat !== e.rp) begin
               failures++;
               $display("FAIL event actual=cyc%0d press=%b rel=%b long=%b rep=%b required=cyc%0d press=%b rel=%b long=%b rep=%b",
                        cyc, o_press, o_release, o_long, o_repeat, e.cyc, e.pr, e.rl, e.lg, e.rp);
            end
         end
      end
   endtask

   task automatic run_stimulus();
      int c;
      int t;
      int n_pr, n_rl, n_lg, n_rp;

      // Reset with all keys pressed at the pin.
      rst_n = 1'b0;
      i_in  = 4'b0000;
      i_in2 = 4'b1111;
      wait_cyc(3);
      chk("reset_pressed", o_pressed, 4'b0000);
      chk("reset_pulses", o_press | o_release | o_long | o_repeat, 4'b0000);

      // Keys held across reset release count as a new press.
      c = cyc;
      push(c + 6, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
      push(c + 14, 4'b0000, 4'b1111, 4'b0000, 4'b0000);
      rst_n = 1'b1;
      wait_cyc(7);
      chk("after_reset_pressed", o_pressed, 4'b1111);
      wait_cyc(1);
      i_in = 4'b1111;
      wait_cyc(8);
      chk("after_release_pressed", o_pressed, 4'b0000);
      chk_int("reset_phase_drained", q.size(), 0);

      // Bounce on ch0: 3-cycle segments never accepted, final level accepted once.
      for (int i = 0; i < 10; i++) begin
         i_in[0] = (i % 2 == 0) ? 1'b0 : 1'b1;
         wait_cyc(3);
      end
      c = cyc;
      i_in[0] = 1'b0;
      push(c + 6, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
      wait_cyc(7);
      chk("bounce_pressed", o_pressed, 4'b0001);
      wait_cyc(3);
      i_in[0] = 1'b1;
      push(c + 16, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
      wait_cyc(8);
      chk("bounce_released", o_pressed, 4'b0000);
      chk_int("bounce_drained", q.size(), 0);

      // Long press and auto-repeat on ch1; release collides with a repeat and wins.
      c = cyc;
      t = c + 6;
      i_in[1] = 1'b0;
      push(t, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
      push(t + 20, 4'b0000, 4'b0000, 4'b0010, 4'b0000);
      for (int k = 0; k < 7; k++) push(t + 25 + 5 * k, 4'b0000, 4'b0000, 4'b0000, 4'b0010);
      push(t + 60, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
      wait_cyc(60);
      i_in[1] = 1'b1;
      wait_cyc(10);
      chk_int("long_repeat_drained", q.size(), 0);

      // Release accepted exactly on the long-press cycle on ch2.
      c = cyc;
      i_in[2] = 1'b0;
      push(c + 6, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
      push(c + 26, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
      wait_cyc(20);
      i_in[2] = 1'b1;
      wait_cyc(10);
      chk("hold_boundary_pressed", o_pressed, 4'b0000);
      chk_int("hold_boundary_drained", q.size(), 0);

      // Repeat disabled build: one long press, no repeats.
      c = cyc;
      n_pr = 0; n_rl = 0; n_lg = 0; n_rp = 0;
      i_in2[0] = 1'b0;
      for (int n = 0; n < 115; n++) begin
         wait_cyc(1);
         n_pr += int'(o_press2[0]);
         n_rl += int'(o_release2[0]);
         n_lg += int'(o_long2[0]);
         n_rp += int'(o_repeat2[0]);
         if (cyc - c == 100) i_in2[0] = 1'b1;
      end
      chk_int("norep_press_count", n_pr, 1);
      chk_int("norep_long_count", n_lg, 1);
      chk_int("norep_repeat_count", n_rp, 0);
      chk_int("norep_release_count", n_rl, 1);

      // Independent channels, then async reset while ch0 is in the held state.
      c = cyc;
      i_in = 4'b0110;
      push(c + 6, 4'b1001, 4'b0000, 4'b0000, 4'b0000);
      push(c + 16, 4'b0000, 4'b1000, 4'b0000, 4'b0000);
      push(c + 26, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
      push(c + 31, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
      wait_cyc(10);
      i_in[3] = 1'b1;
      wait_cyc(23);
      chk("indep_pressed", o_pressed, 4'b0001);
      rst_n = 1'b0;
      #1;
      chk("async_reset_pressed", o_pressed, 4'b0000);
      chk("async_reset_pulses", o_press | o_release | o_long | o_repeat, 4'b0000);
      wait_cyc(2);
      i_in = 4'b1111;
      wait_cyc(4);
      rst_n = 1'b1;
      wait_cyc(12);
      chk("post_reset_pressed", o_pressed, 4'b0000);
      chk_int("final_drained", q.size(), 0);
   endtask

   initial begin
      fork
         begin
            forever begin
               @(negedge clk);
               monitor_step();
            end
         end
         run_stimulus();
      join_any
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
